// File: rtl/pe_inject_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : pe_inject_arbiter_if
//  Brief   : Bundle of the PE-side request bus and the switch-side injection
//            bus of the PE injection arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
interface pe_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  // Requester side
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        i_data_valid;
  logic [NUM_REQ-1:0]        o_data_ready;
  // Switch side
  logic [DATA_W-1:0]         o_data;
  logic                      o_data_valid;
  logic                      i_data_ready;
  // Status
  logic [3:0]                o_grant_id;
  logic                      o_drop;
  logic [31:0]               o_fwd_count;
  logic [31:0]               o_drop_count;

  // Arbiter view
  modport slave (
    input  i_data, i_data_valid, i_data_ready,
    output o_data_ready, o_data, o_data_valid, o_grant_id, o_drop,
           o_fwd_count, o_drop_count
  );

  // Environment view (PEs plus switch)
  modport master (
    output i_data, i_data_valid, i_data_ready,
    input  o_data_ready, o_data, o_data_valid, o_grant_id, o_drop,
           o_fwd_count, o_drop_count
  );
endinterface
`default_nettype wire

// File: rtl/pe_inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : pe_inject_arbiter
//  Brief   : Round-robin merge of NUM_REQ PE packet streams onto one NoC
//            injection port, with a one-entry output register, filtering of
//            packets addressed to non-existent PEs, and traffic counters.
//  Rev     : 1.0  initial release
// ============================================================================
module pe_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_PE  = 4,
  parameter int DATA_W  = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pe_inject_arbiter_if.slave  bus
);

  localparam logic [4:0] c_num_req = 5'(NUM_REQ);
  localparam logic [8:0] c_num_pe  = 9'(NUM_PE);

  // Registered state
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [3:0]        r_grant_id;
  logic              r_drop;
  logic [31:0]       r_fwd_cnt;
  logic [31:0]       r_drop_cnt;
  logic [3:0]        r_ptr;

  // Combinational
  logic              w_load_ok;
  logic              w_out_xfer;
  logic [15:0]       w_valid_ext;
  logic              w_gnt_any;
  logic [3:0]        w_gnt_idx;
  logic [4:0]        w_sum;
  logic [NUM_REQ-1:0] w_ready;
  logic [DATA_W-1:0] w_sel;
  logic              w_legal;
  logic [4:0]        w_inc;
  logic [3:0]        w_ptr_nxt;

  // A new packet may be taken when the register is empty or draining now
  assign w_load_ok   = ~r_valid | bus.i_data_ready;
  assign w_out_xfer  = r_valid & bus.i_data_ready;
  // Zero-extend so the rotating index can address any requester count
  assign w_valid_ext = 16'(bus.i_data_valid);

  // Rotating priority scan starting at r_ptr; first valid requester wins
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    if (w_load_ok && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_sum = {1'b0, r_ptr} + 5'(i);
        if (w_sum >= c_num_req) begin
          w_sum = w_sum - c_num_req;
        end
        if (!w_gnt_any && w_valid_ext[w_sum[3:0]]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_sum[3:0];
        end
      end
    end
  end

  // One-hot accept toward the winning requester
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_ready[k] = w_gnt_any && (w_gnt_idx == 4'(k));
    end
  end

  // Select the winner's packet; used only to feed registers
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_idx == 4'(k)) begin
        w_sel = bus.i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Destination lives in the top byte; legal when below the PE count
  assign w_legal = ({1'b0, w_sel[DATA_W-1 -: 8]} < c_num_pe);

  // Pointer moves to the requester after the one just served
  always_comb begin
    w_inc     = {1'b0, w_gnt_idx} + 5'd1;
    w_ptr_nxt = w_inc[3:0];
    if (w_inc >= c_num_req) begin
      w_ptr_nxt = 4'(w_inc - c_num_req);
    end
  end

  // Output register, pointer, drop pulse and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_grant_id <= '0;
      r_drop     <= 1'b0;
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ptr      <= '0;
    end else begin
      r_drop <= w_gnt_any & ~w_legal;
      if (w_gnt_any && w_legal) begin
        r_data     <= w_sel;
        r_valid    <= 1'b1;
        r_grant_id <= w_gnt_idx;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_gnt_any) begin
        r_ptr <= w_ptr_nxt;
        if (!w_legal) begin
          r_drop_cnt <= r_drop_cnt + 32'd1;
        end
      end
      if (w_out_xfer) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign bus.o_data_ready = w_ready;
  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_valid;
  assign bus.o_grant_id   = r_grant_id;
  assign bus.o_drop       = r_drop;
  assign bus.o_fwd_count  = r_fwd_cnt;
  assign bus.o_drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pe_inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pe_inject_arbiter
//  Brief   : Scoreboard bench for pe_inject_arbiter with a round-robin
//            reference model and randomized traffic.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pe_inject_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_inject_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  pe_inject_arbiter #(.NUM_REQ(N), .NUM_PE(4), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef logic [31:0] pq_t[$];
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  pq_t  src [N];
  bit   held [N];
  int   rate [N];
  int   rdy_rate = 100;
  exp_t expq[$];
  int   glog[$];

  // Reference model state
  int          m_ptr  = 0;
  bit          m_full = 1'b0;
  logic [31:0] m_fwd  = '0;
  logic [31:0] m_drop = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: scan upward from the pointer when a load is possible
  function automatic int exp_grant();
    if (rst) return -1;
    if (m_full && !bus.i_data_ready) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (bus.i_data_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit pending();
    bit p;
    p = m_full;
    for (int k = 0; k < N; k++) if (src[k].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock cycle: drive at negedge, check accepts, update model after edge
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic [31:0]  pkt;
    int           g;
    bit           legal;
    bit           out_x;
    bit           exp_drop;
    exp_t         e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (!held[k] && src[k].size() > 0 && $urandom_range(0, 99) < rate[k]) held[k] = 1'b1;
      v[k] = held[k];
      bus.i_data[k*DW +: DW] = (src[k].size() > 0) ? src[k][0] : $urandom();
    end
    bus.i_data_valid = v;
    bus.i_data_ready = ($urandom_range(0, 99) < rdy_rate);
    #1;
    g = exp_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("o_data_ready", 64'(bus.o_data_ready), 64'(exp_rdy));
    chk("o_data_valid", 64'(bus.o_data_valid), 64'(m_full));
    legal = 1'b0;
    if (g >= 0) begin
      pkt = src[g].pop_front();
      held[g] = 1'b0;
      legal = (pkt[31:24] < 8'd4);
      glog.push_back(g);
      if (legal) begin
        e.id   = 4'(g);
        e.data = pkt;
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    exp_drop = 1'b0;
    if (rst) begin
      m_ptr = 0; m_full = 1'b0; m_fwd = '0; m_drop = '0;
      expq.delete();
    end else begin
      out_x = m_full && bus.i_data_ready;
      if (out_x) m_fwd = m_fwd + 32'd1;
      if (g >= 0 && legal) m_full = 1'b1;
      else if (out_x) m_full = 1'b0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (!legal) begin
          m_drop   = m_drop + 32'd1;
          exp_drop = 1'b1;
        end
      end
    end
    chk("o_drop", 64'(bus.o_drop), 64'(exp_drop));
    chk("o_fwd_count", 64'(bus.o_fwd_count), 64'(m_fwd));
    chk("o_drop_count", 64'(bus.o_drop_count), 64'(m_drop));
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (pending() && cycles < budget) begin
      step();
      cycles++;
    end
    if (pending()) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: still pending after %0d cycles", budget);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected packet
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (bus.o_data_valid === 1'b1 && bus.i_data_ready === 1'b1) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_unexpected: got %0h expected no transfer", bus.o_data);
        end else begin
          e = expq.pop_front();
          chk("o_data", 64'(bus.o_data), 64'(e.data));
          chk("o_grant_id", 64'(bus.o_grant_id), 64'(e.id));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          pos;
    logic [31:0] saved;
    bus.i_data       = '0;
    bus.i_data_valid = '0;
    bus.i_data_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      held[k] = 1'b0;
      rate[k] = 100;
    end

    // Reset with every requester valid; full-load traffic queued behind it
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 100; i++)
        src[k].push_back({8'(k), 24'(100 * k + i)});
    rst = 1'b1;
    repeat (3) step();
    chk("reset_ready", 64'(bus.o_data_ready), 64'd0);
    chk("reset_fwd", 64'(bus.o_fwd_count), 64'd0);
    rst = 1'b0;

    // Full-load fairness
    glog.delete();
    drain(1000, cyc);
    chk("load_cycles", 64'(cyc), 64'd401);
    chk("load_fwd_400", 64'(bus.o_fwd_count), 64'd400);
    chk("first_grant0", 64'(glog[0]), 64'd0);
    chk("first_grant1", 64'(glog[1]), 64'd1);
    chk("first_grant3", 64'(glog[3]), 64'd3);

    // Backpressure on requester 2
    for (int k = 0; k < N; k++) rate[k] = 0;
    rate[2] = 100;
    for (int i = 0; i < 3; i++) src[2].push_back({8'd2, 24'(24'hB00 + i)});
    rdy_rate = 0;
    step();
    saved = bus.o_data;
    chk("bp_loaded", 64'(saved), 64'({8'd2, 24'hB00}));
    repeat (5) begin
      step();
      chk("bp_stable", 64'(bus.o_data), 64'(saved));
    end
    rdy_rate = 100;
    glog.delete();
    step();
    chk("bp_reload_same_cycle", 64'(glog.size()), 64'd1);
    drain(50, cyc);

    // Illegal destination on requester 1
    for (int k = 0; k < N; k++) rate[k] = 0;
    rate[1] = 100;
    src[1].push_back({8'd7, 24'h0000AA});
    src[1].push_back({8'd3, 24'h0000BB});
    drain(50, cyc);
    chk("drop_count_1", 64'(bus.o_drop_count), 64'd1);

    // Sparse rotation from pointer 2, requester 0 joins mid-stream
    rate[1] = 100;
    rate[3] = 100;
    for (int i = 0; i < 4; i++) begin
      src[1].push_back({8'd1, 24'(24'h100 + i)});
      src[3].push_back({8'd3, 24'(24'h300 + i)});
    end
    glog.delete();
    repeat (4) step();
    chk("sparse_g0", 64'(glog[0]), 64'd3);
    chk("sparse_g1", 64'(glog[1]), 64'd1);
    chk("sparse_g2", 64'(glog[2]), 64'd3);
    chk("sparse_g3", 64'(glog[3]), 64'd1);
    rate[0] = 100;
    src[0].push_back({8'd0, 24'h000C0});
    drain(50, cyc);
    pos = -1;
    for (int i = glog.size() - 1; i >= 4; i--) if (glog[i] == 0) pos = i;
    chk("starvation_bound", 64'(pos >= 4 && pos < 8), 64'd1);

    // Randomized traffic, random destinations including illegal ones
    for (int k = 0; k < N; k++) begin
      rate[k] = $urandom_range(30, 100);
      for (int i = 0; i < 30; i++)
        src[k].push_back({8'($urandom_range(0, 7)), 24'($urandom())});
    end
    rdy_rate = 60;
    drain(3000, cyc);

    // Mid-run reset with a packet held in the output register
    for (int k = 0; k < N; k++) rate[k] = 0;
    rate[0] = 100;
    for (int i = 0; i < 3; i++) src[0].push_back({8'd0, 24'(24'hD00 + i)});
    rdy_rate = 0;
    step();
    chk("pre_reset_full", 64'(bus.o_data_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_reset_valid", 64'(bus.o_data_valid), 64'd0);
    chk("post_reset_fwd", 64'(bus.o_fwd_count), 64'd0);
    rate[2] = 100;
    src[2].push_back({8'd2, 24'hE00});
    rdy_rate = 100;
    glog.delete();
    step();
    chk("post_reset_ptr0", 64'(glog[0]), 64'd0);
    drain(50, cyc);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
